bht_ctrl: RTL and testbench

Branch history table controller. It holds DEPTH independent 2-bit predictor states, uses the team's standard predictor encoding and transitions, and arbitrates one shared table access port between fetch-side lookups and execute-side updates. After reset it sweeps every entry to the reset state before accepting traffic. It also keeps saturating update and mispredict counters for performance monitoring.

---
 rtl/bht_ctrl.sv | 134 +++++++++++++
 tb/tb_bht_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_ctrl.sv
// Branch history table controller: 2-bit predictors behind one shared
// table port, arbitrating fetch lookups against buffered execute updates.
module bht_ctrl #(
   parameter int IDX_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             lookup_valid,
   input  logic [IDX_W-1:0] lookup_idx,
   output logic             lookup_ready,
   output logic             pred_valid,
   output logic             pred_taken,
   input  logic             upd_valid,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken,
   output logic             upd_ready,
   output logic             init_busy,
   output logic [CNT_W-1:0] update_count,
   output logic [CNT_W-1:0] mispredict_count
);

   localparam int DEPTH = 1 << IDX_W;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [IDX_W-1:0] sweep;
   logic [1:0]       tbl [DEPTH];

   logic             buf_valid;
   logic [IDX_W-1:0] buf_idx;
   logic             buf_taken;

   logic       lookup_fire;
   logic       upd_fire;
   logic [1:0] cur;
   logic [1:0] nxt;
   logic       mispredict;

   // 00/01 predict taken, 10/11 predict not-taken
   function automatic logic [1:0] next_state(
      input logic [1:0] s,
      input logic       taken
   );
      logic [1:0] n;
      n = s;
      unique case ({taken, s})
         3'b1_00: n = 2'b00;
         3'b1_01: n = 2'b00;
         3'b1_10: n = 2'b11;
         3'b1_11: n = 2'b00;
         3'b0_00: n = 2'b01;
         3'b0_01: n = 2'b10;
         3'b0_10: n = 2'b10;
         3'b0_11: n = 2'b10;
         default: n = s;
      endcase
      return n;
   endfunction

   always_comb begin
      state_nxt    = state;
      init_busy    = 1'b0;
      lookup_ready = 1'b0;
      upd_ready    = 1'b0;
      unique case (state)
         INIT: begin
            init_busy = 1'b1;
            if (sweep == '1)
               state_nxt = RUN;
         end
         RUN: begin
            lookup_ready = ~buf_valid;
            upd_ready    = ~buf_valid;
         end
         default: state_nxt = INIT;
      endcase
   end

   assign lookup_fire = lookup_valid & lookup_ready;
   assign upd_fire    = upd_valid & upd_ready;
   assign cur         = tbl[buf_idx];
   assign nxt         = next_state(cur, buf_taken);
   assign mispredict  = (~cur[1]) != buf_taken;

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= INIT;
         sweep            <= '0;
         buf_valid        <= 1'b0;
         buf_idx          <= '0;
         buf_taken        <= 1'b0;
         pred_valid       <= 1'b0;
         pred_taken       <= 1'b0;
         update_count     <= '0;
         mispredict_count <= '0;
      end else begin
         state      <= state_nxt;
         pred_valid <= lookup_fire;
         if (lookup_fire)
            pred_taken <= ~tbl[lookup_idx][1];
         if (state == INIT)
            sweep <= sweep + IDX_W'(1);
         if (buf_valid) begin
            buf_valid <= 1'b0;
            if (update_count != '1)
               update_count <= update_count + CNT_W'(1);
            if (mispredict && mispredict_count != '1)
               mispredict_count <= mispredict_count + CNT_W'(1);
         end else if (upd_fire) begin
            buf_valid <= 1'b1;
            buf_idx   <= upd_idx;
            buf_taken <= upd_taken;
         end
      end
   end

   // Table storage has no reset; the INIT sweep establishes its contents
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == INIT)
            tbl[sweep] <= 2'b00;
         else if (buf_valid)
            tbl[buf_idx] <= nxt;
      end
   end

endmodule

// File: tb/tb_bht_ctrl.sv
// Randomised self-checking bench for bht_ctrl against a behavioural
// model of the predictor table, update buffer and counters.
module tb_bht_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        lookup_valid;
   logic [3:0]  lookup_idx;
   logic        upd_valid;
   logic [3:0]  upd_idx;
   logic        upd_taken;
   logic        lookup_ready, pred_valid, pred_taken;
   logic        upd_ready, init_busy;
   logic [15:0] update_count, mispredict_count;
   logic        s_lr, s_pv, s_pt, s_ur, s_ib;
   logic [1:0]  s_upd, s_mis;

   int tests_run = 0;
   int tests_failed = 0;

   int  m_tbl [16];
   bit  m_init, m_buf, m_btaken, m_pv, m_pt;
   int  m_sweep, m_bidx, m_upd, m_mis;
   int  nx_t [4] = '{0, 0, 3, 0};
   int  nx_n [4] = '{1, 2, 2, 2};

   always #5 clk = ~clk;

   bht_ctrl #(.IDX_W(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .lookup_valid(lookup_valid), .lookup_idx(lookup_idx),
      .lookup_ready(lookup_ready),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .upd_valid(upd_valid), .upd_idx(upd_idx),
      .upd_taken(upd_taken), .upd_ready(upd_ready),
      .init_busy(init_busy), .update_count(update_count),
      .mispredict_count(mispredict_count)
   );

   bht_ctrl #(.IDX_W(4), .CNT_W(2)) sat (
      .clk(clk), .reset(reset),
      .lookup_valid(lookup_valid), .lookup_idx(lookup_idx),
      .lookup_ready(s_lr),
      .pred_valid(s_pv), .pred_taken(s_pt),
      .upd_valid(upd_valid), .upd_idx(upd_idx),
      .upd_taken(upd_taken), .upd_ready(s_ur),
      .init_busy(s_ib), .update_count(s_upd),
      .mispredict_count(s_mis)
   );

   function automatic logic [15:0] sat16(input int v);
      return (v > 65535) ? 16'hffff : 16'(v);
   endfunction

   function automatic logic [1:0] sat2(input int v);
      return (v > 3) ? 2'd3 : 2'(v);
   endfunction

   function automatic bit m_rdy();
      return !m_init && !m_buf;
   endfunction

   // Advance the model by one clock using the inputs now applied,
   // then move to the next falling edge where outputs are settled.
   task automatic tick();
      int s;
      if (reset) begin
         m_init = 1; m_sweep = 0; m_buf = 0;
         m_upd = 0; m_mis = 0; m_pv = 0; m_pt = 0;
      end else if (m_init) begin
         m_tbl[m_sweep] = 0;
         m_sweep++;
         if (m_sweep == 16) m_init = 0;
         m_pv = 0;
      end else begin
         m_pv = 0;
         if (m_buf) begin
            s = m_tbl[m_bidx];
            m_upd++;
            if ((s < 2) != m_btaken) m_mis++;
            m_tbl[m_bidx] = m_btaken ? nx_t[s] : nx_n[s];
            m_buf = 0;
         end else begin
            if (lookup_valid) begin
               m_pv = 1;
               m_pt = (m_tbl[lookup_idx] < 2);
            end
            if (upd_valid) begin
               m_buf = 1;
               m_bidx = int'(upd_idx);
               m_btaken = upd_taken;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      lookup_valid = 0;
      upd_valid = 0;
   endtask

   task automatic test_reset();
      int n;
      reset = 1;
      idle();
      tick();
      tick();
      tests_run++;
      if ({init_busy, lookup_ready, upd_ready, pred_valid, pred_taken}
          !== 5'b10000) begin
         tests_failed++;
         $display("FAIL reset_ctl got %b want 10000",
            {init_busy, lookup_ready, upd_ready, pred_valid, pred_taken});
      end
      tests_run++;
      if (update_count !== 0 || mispredict_count !== 0) begin
         tests_failed++;
         $display("FAIL reset_cnt got %0d/%0d want 0/0",
            update_count, mispredict_count);
      end
      reset = 0;
      n = 0;
      while (init_busy === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      tests_run++;
      if (n != 16) begin
         tests_failed++;
         $display("FAIL init_len got %0d want 16", n);
      end
      tests_run++;
      if (lookup_ready !== 1'b1 || upd_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL init_ready got %b%b want 11",
            lookup_ready, upd_ready);
      end
      for (int i = 0; i < 16; i++) begin
         lookup_valid = 1;
         lookup_idx = 4'(i);
         tick();
         tests_run++;
         if (pred_valid !== 1'b1 || pred_taken !== 1'b1) begin
            tests_failed++;
            $display("FAIL init_pred idx %0d got v%b t%b want v1 t1",
               i, pred_valid, pred_taken);
         end
      end
      idle();
      tick();
   endtask

   task automatic test_idx3_sequence();
      bit outc [5] = '{0, 0, 0, 1, 1};
      bit exp  [5] = '{1, 0, 0, 0, 1};
      int u0;
      u0 = m_upd;
      for (int k = 0; k < 5; k++) begin
         upd_valid = 1;
         upd_idx = 4'd3;
         upd_taken = outc[k];
         tick();
         idle();
         tick();
         lookup_valid = 1;
         lookup_idx = 4'd3;
         tick();
         lookup_valid = 0;
         tests_run++;
         if (pred_valid !== 1'b1 || pred_taken !== exp[k]) begin
            tests_failed++;
            $display("FAIL idx3_pred step %0d got v%b t%b want v1 t%0d",
               k, pred_valid, pred_taken, exp[k]);
         end
      end
      tests_run++;
      if (update_count !== sat16(m_upd) || m_upd - u0 != 5) begin
         tests_failed++;
         $display("FAIL idx3_upd got %0d want %0d",
            update_count, u0 + 5);
      end
      tests_run++;
      if (mispredict_count !== sat16(m_mis)) begin
         tests_failed++;
         $display("FAIL idx3_mis got %0d want %0d",
            mispredict_count, m_mis);
      end
   endtask

   task automatic test_same_cycle();
      lookup_valid = 1;
      lookup_idx = 4'd5;
      upd_valid = 1;
      upd_idx = 4'd5;
      upd_taken = 0;
      tick();
      idle();
      tests_run++;
      if (pred_valid !== 1'b1 || pred_taken !== 1'b1) begin
         tests_failed++;
         $display("FAIL same_pred got v%b t%b want v1 t1",
            pred_valid, pred_taken);
      end
      tests_run++;
      if (lookup_ready !== 1'b0 || upd_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL same_busy got %b%b want 00",
            lookup_ready, upd_ready);
      end
      tick();
      tests_run++;
      if (lookup_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL same_ready got %b want 1", lookup_ready);
      end
      lookup_valid = 1;
      lookup_idx = 4'd5;
      tick();
      idle();
      tests_run++;
      if (pred_valid !== 1'b1 || pred_taken !== 1'b1) begin
         tests_failed++;
         $display("FAIL same_after got v%b t%b want v1 t1",
            pred_valid, pred_taken);
      end
   endtask

   task automatic test_back_to_back();
      int acc_l, acc_u, got_p, u0;
      logic prev;
      acc_l = 0; acc_u = 0; got_p = 0;
      u0 = m_upd;
      prev = 1'b0;
      for (int c = 0; c < 20; c++) begin
         lookup_valid = 1;
         upd_valid = 1;
         lookup_idx = 4'($urandom_range(0, 15));
         upd_idx = 4'($urandom_range(0, 15));
         upd_taken = 1'($urandom);
         tests_run++;
         if (upd_ready !== (c % 2 == 0) || lookup_ready !== upd_ready)
         begin
            tests_failed++;
            $display("FAIL b2b_ready cyc %0d got u%b l%b want %0d",
               c, upd_ready, lookup_ready, c % 2 == 0);
         end
         prev = lookup_ready;
         if (prev === 1'b1) begin
            acc_l++;
            acc_u++;
         end
         tick();
         if (pred_valid === 1'b1) got_p++;
         tests_run++;
         if (pred_valid !== m_pv || (m_pv && pred_taken !== m_pt)) begin
            tests_failed++;
            $display("FAIL b2b_pred cyc %0d got v%b t%b want v%0d t%0d",
               c, pred_valid, pred_taken, m_pv, m_pt);
         end
      end
      idle();
      tick();
      if (pred_valid === 1'b1) got_p++;
      tests_run++;
      if (got_p != acc_l) begin
         tests_failed++;
         $display("FAIL b2b_lost got %0d preds want %0d", got_p, acc_l);
      end
      tests_run++;
      if (int'(update_count) - u0 != acc_u) begin
         tests_failed++;
         $display("FAIL b2b_drop got %0d upds want %0d",
            int'(update_count) - u0, acc_u);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         lookup_valid = 1'($urandom_range(0, 1));
         upd_valid = 1'($urandom_range(0, 2) == 0);
         lookup_idx = 4'($urandom_range(0, 15));
         upd_idx = 4'($urandom_range(0, 15));
         upd_taken = 1'($urandom);
         tests_run++;
         if (lookup_ready !== m_rdy() || upd_ready !== m_rdy()) begin
            tests_failed++;
            $display("FAIL rnd_ready cyc %0d got l%b u%b want %0d",
               c, lookup_ready, upd_ready, m_rdy());
         end
         tick();
         tests_run++;
         if (pred_valid !== m_pv || (m_pv && pred_taken !== m_pt)) begin
            tests_failed++;
            $display("FAIL rnd_pred cyc %0d got v%b t%b want v%0d t%0d",
               c, pred_valid, pred_taken, m_pv, m_pt);
         end
         tests_run++;
         if (update_count !== sat16(m_upd) ||
             mispredict_count !== sat16(m_mis)) begin
            tests_failed++;
            $display("FAIL rnd_cnt cyc %0d got %0d/%0d want %0d/%0d",
               c, update_count, mispredict_count, m_upd, m_mis);
         end
      end
      idle();
      tick();
   endtask

   task automatic test_saturation();
      int r;
      for (int k = 0; k < 5; k++) begin
         r = $urandom_range(0, 15);
         upd_valid = 1;
         upd_idx = 4'(r);
         upd_taken = !(m_tbl[r] < 2);
         tick();
         idle();
         tick();
      end
      tests_run++;
      if (s_mis !== sat2(m_mis) || s_mis !== 2'd3) begin
         tests_failed++;
         $display("FAIL sat_mis got %0d want 3", s_mis);
      end
      tests_run++;
      if (s_upd !== sat2(m_upd) || s_upd !== 2'd3) begin
         tests_failed++;
         $display("FAIL sat_upd got %0d want 3", s_upd);
      end
      tests_run++;
      if (mispredict_count !== sat16(m_mis)) begin
         tests_failed++;
         $display("FAIL sat_wide got %0d want %0d",
            mispredict_count, m_mis);
      end
      tests_run++;
      if ({s_lr, s_ur, s_ib, s_pv} !== {m_rdy(), m_rdy(), m_init, m_pv})
      begin
         tests_failed++;
         $display("FAIL sat_ctl got %b want %b", {s_lr, s_ur, s_ib, s_pv},
            {m_rdy(), m_rdy(), m_init, m_pv});
      end
   endtask

   task automatic test_reset_pending();
      int n;
      upd_valid = 1;
      upd_idx = 4'd7;
      upd_taken = 0;
      tick();
      idle();
      reset = 1;
      tick();
      reset = 0;
      tests_run++;
      if (init_busy !== 1'b1 || lookup_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstp_busy got b%b l%b want b1 l0",
            init_busy, lookup_ready);
      end
      tests_run++;
      if (update_count !== 0 || mispredict_count !== 0) begin
         tests_failed++;
         $display("FAIL rstp_cnt got %0d/%0d want 0/0",
            update_count, mispredict_count);
      end
      n = 0;
      while (init_busy === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      tests_run++;
      if (n != 16) begin
         tests_failed++;
         $display("FAIL rstp_init got %0d want 16", n);
      end
      lookup_valid = 1;
      lookup_idx = 4'd7;
      tick();
      idle();
      tests_run++;
      if (pred_valid !== 1'b1 || pred_taken !== 1'b1) begin
         tests_failed++;
         $display("FAIL rstp_pred got v%b t%b want v1 t1",
            pred_valid, pred_taken);
      end
      tests_run++;
      if (update_count !== 0) begin
         tests_failed++;
         $display("FAIL rstp_noapply got %0d want 0", update_count);
      end
   endtask

   initial begin
      reset = 1;
      lookup_valid = 0;
      lookup_idx = 0;
      upd_valid = 0;
      upd_idx = 0;
      upd_taken = 0;
      for (int i = 0; i < 16; i++) m_tbl[i] = 0;
      test_reset();
      test_idx3_sequence();
      test_same_cycle();
      test_back_to_back();
      test_random();
      test_saturation();
      test_reset_pending();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
